// File: rtl/pipeline_run_ctrl_if.sv
// Control/status bundle between the run/halt sequencer and the core front end.
// master drives requests and fetch context; slave is the sequencer itself.
interface pipeline_run_ctrl_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             halt_i;
  logic             step_i;
  logic             fetch_ok_i;
  logic [PC_W-1:0]  pc_f_i;
  logic             bp_en_i;
  logic [PC_W-1:0]  bp_addr_i;
  logic             clr_cnt_i;
  logic             run_en_o;
  logic             halted_o;
  logic             bp_hit_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    output start_i, halt_i, step_i, fetch_ok_i, pc_f_i, bp_en_i, bp_addr_i, clr_cnt_i,
    input  run_en_o, halted_o, bp_hit_o, state_o, cycle_cnt_o, fetch_cnt_o
  );

  modport slave (
    input  start_i, halt_i, step_i, fetch_ok_i, pc_f_i, bp_en_i, bp_addr_i, clr_cnt_i,
    output run_en_o, halted_o, bp_hit_o, state_o, cycle_cnt_o, fetch_cnt_o
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/halt/single-step sequencer producing the fetch-side enable for the 5-stage core.
// Define RUN_CTRL_BREAKPOINT_EN to build the PC breakpoint and resume-skip logic.
module pipeline_run_ctrl #(
  parameter int HOLD_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_HALTED = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  localparam int TMR_MAX = (HOLD_CYCLES > DRAIN_CYCLES) ? HOLD_CYCLES : DRAIN_CYCLES;
  localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             run_en_s, fetch_s, arm_s, bp_stop_s, bp_match_s, bp_hit_s;

  // Next-state and fetch-enable decode; the breakpoint gates the enable in the same cycle.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    run_en_s  = 1'b0;
    arm_s     = 1'b0;
    bp_stop_s = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = S_HALTED;
          tmr_d   = {TMR_W{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_HALTED: begin
        if (bus.halt_i) begin
          state_d = S_HALTED;
        end else if (bus.start_i) begin
          state_d = S_RUN;
          arm_s   = 1'b1;
        end else if (bus.step_i) begin
          state_d = S_STEP;
          arm_s   = 1'b1;
        end else begin
          state_d = S_HALTED;
        end
      end
      S_RUN: begin
        run_en_s  = ~bp_match_s;
        bp_stop_s = bp_match_s;
        if (bus.halt_i | bp_match_s) begin
          state_d = S_DRAIN;
          tmr_d   = {TMR_W{1'b0}};
        end else begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        run_en_s = 1'b1;
        if (bus.halt_i | bus.fetch_ok_i) begin
          state_d = S_DRAIN;
          tmr_d   = {TMR_W{1'b0}};
        end else begin
          state_d = S_STEP;
        end
      end
      S_DRAIN: begin
        if (tmr_q == DRAIN_LAST) begin
          state_d = S_HALTED;
          tmr_d   = {TMR_W{1'b0}};
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_HALTED;
        tmr_d   = {TMR_W{1'b0}};
      end
    endcase
  end

  assign fetch_s  = run_en_s & bus.fetch_ok_i;
  assign halted_d = (state_d == S_HALTED);

  // Counter update; a clear overrides a coincident increment.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (bus.clr_cnt_i) begin
      cycle_cnt_d = {CNT_W{1'b0}};
      fetch_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (state_q != S_HOLD) begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end else begin
        cycle_cnt_d = cycle_cnt_q;
      end
      if (fetch_s) begin
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
      end else begin
        fetch_cnt_d = fetch_cnt_q;
      end
    end
  end

  // Sequencer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      tmr_q       <= {TMR_W{1'b0}};
      halted_q    <= 1'b0;
      cycle_cnt_q <= {CNT_W{1'b0}};
      fetch_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      halted_q    <= halted_d;
      cycle_cnt_q <= cycle_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic            skip_q, skip_d, bp_hit_q, bp_hit_d;
  logic [PC_W-1:0] bp_addr_s;

  // Skip lets a resume from the breakpoint PC fetch that instruction exactly once.
  assign bp_addr_s  = bus.bp_addr_i;
  assign bp_match_s = bus.bp_en_i & (bus.pc_f_i == bp_addr_s) & ~skip_q;

  // Skip flag and sticky hit flag update.
  always_comb begin
    skip_d   = skip_q;
    bp_hit_d = bp_hit_q;
    if (arm_s) begin
      skip_d   = 1'b1;
      bp_hit_d = 1'b0;
    end else if (fetch_s) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end
    if (bp_stop_s) begin
      bp_hit_d = 1'b1;
    end else begin
      bp_hit_d = bp_hit_d;
    end
  end

  // Breakpoint state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
    end else begin
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit_s = bp_hit_q;
`else
  logic [PC_W-1:0] unused_bp_addr_s;
  logic            unused_bp_s;

  assign bp_match_s       = 1'b0;
  assign bp_hit_s         = 1'b0;
  assign unused_bp_addr_s = bus.bp_addr_i ^ bus.pc_f_i;
  assign unused_bp_s      = bus.bp_en_i ^ arm_s ^ bp_stop_s;
`endif

  assign bus.run_en_o    = run_en_s;
  assign bus.halted_o    = halted_q;
  assign bus.bp_hit_o    = bp_hit_s;
  assign bus.state_o     = state_q;
  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Randomized and directed bench for pipeline_run_ctrl against a cycle-level behavioural model.
module tb_pipeline_run_ctrl;
  localparam int HOLD  = 2;
  localparam int DRAIN = 4;
  localparam int M_HOLD = 0, M_HALTED = 1, M_RUN = 2, M_STEP = 3, M_DRAIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_run_ctrl_if #(.PC_W(8), .CNT_W(16)) bus ();

  pipeline_run_ctrl #(
    .HOLD_CYCLES(HOLD), .DRAIN_CYCLES(DRAIN), .PC_W(8), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, cycles left in a timed mode, skip/hit flags, counters.
  int m_mode = M_HOLD;
  int m_left = HOLD;
  bit m_skip = 1'b0;
  bit m_hit  = 1'b0;
  int m_cyc  = 0;
  int m_fet  = 0;
  bit m_bpm_v, m_fetch_v;

  function automatic bit m_bp();
`ifdef RUN_CTRL_BREAKPOINT_EN
    return bus.bp_en_i && (bus.pc_f_i == bus.bp_addr_i) && !m_skip;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_run();
    return (m_mode == M_RUN && !m_bp()) || m_mode == M_STEP;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_mode = M_HOLD; m_left = HOLD; m_skip = 1'b0; m_hit = 1'b0; m_cyc = 0; m_fet = 0;
    end else begin
      m_bpm_v   = m_bp();
      m_fetch_v = m_run() && bus.fetch_ok_i;
      if (bus.clr_cnt_i) begin
        m_cyc = 0;
        m_fet = 0;
      end else begin
        if (m_mode != M_HOLD) m_cyc = (m_cyc + 1) % 65536;
        if (m_fetch_v) m_fet = (m_fet + 1) % 65536;
      end
      if (m_fetch_v) m_skip = 1'b0;
      case (m_mode)
        M_HOLD, M_DRAIN: begin
          m_left--;
          if (m_left == 0) m_mode = M_HALTED;
        end
        M_HALTED: if (!bus.halt_i && (bus.start_i || bus.step_i)) begin
          m_mode = bus.start_i ? M_RUN : M_STEP;
          m_skip = 1'b1;
          m_hit  = 1'b0;
        end
        M_RUN: if (bus.halt_i || m_bpm_v) begin
          m_mode = M_DRAIN;
          m_left = DRAIN;
          if (m_bpm_v) m_hit = 1'b1;
        end
        M_STEP: if (bus.halt_i || m_fetch_v) begin
          m_mode = M_DRAIN;
          m_left = DRAIN;
        end
        default: m_mode = M_HALTED;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    check("run_en",    {31'd0, bus.run_en_o}, {31'd0, m_run()});
    check("halted",    {31'd0, bus.halted_o}, (m_mode == M_HALTED) ? 32'd1 : 32'd0);
    check("bp_hit",    {31'd0, bus.bp_hit_o}, {31'd0, m_hit});
    check("state",     {29'd0, bus.state_o}, m_mode);
    check("cycle_cnt", {16'd0, bus.cycle_cnt_o}, m_cyc);
    check("fetch_cnt", {16'd0, bus.fetch_cnt_o}, m_fet);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i = 1'b0; bus.halt_i = 1'b0; bus.step_i = 1'b0; bus.fetch_ok_i = 1'b0;
    bus.pc_f_i = 8'h00; bus.bp_en_i = 1'b0; bus.bp_addr_i = 8'h00; bus.clr_cnt_i = 1'b0;
  endtask

  int hi;

  initial begin
    idle_inputs();
    #2 rst = 1'b0;
    #20;
    @(negedge clk);
    #1;
    check("rst_state", {29'd0, bus.state_o}, 32'd0);
    check("rst_run_en", {31'd0, bus.run_en_o}, 32'd0);
    check("rst_fetch", {16'd0, bus.fetch_cnt_o}, 32'd0);
    rst = 1'b1;

    // HOLD for two cycles, then HALTED with the cycle counter starting.
    tick(); check("hold_1", {29'd0, bus.state_o}, 32'd0);
    tick(); check("hold_exit", {29'd0, bus.state_o}, 32'd1);
    check("halted_after_hold", {31'd0, bus.halted_o}, 32'd1);
    check("cyc_at_halted", {16'd0, bus.cycle_cnt_o}, 32'd0);
    tick(); check("cyc_counts", {16'd0, bus.cycle_cnt_o}, 32'd1);

    // Free run for ten cycles, then a halt.
    bus.start_i = 1'b1; bus.fetch_ok_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    check("run_entered", {29'd0, bus.state_o}, 32'd2);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.run_en_o) hi++;
      tick();
    end
    bus.halt_i = 1'b1;
    if (bus.run_en_o) hi++;
    tick(); bus.halt_i = 1'b0; bus.fetch_ok_i = 1'b0;
    check("run_en_cycles", hi, 32'd11);
    check("fetch_after_run", {16'd0, bus.fetch_cnt_o}, 32'd11);
    check("drain_entered", {29'd0, bus.state_o}, 32'd4);
    for (int i = 0; i < DRAIN - 1; i++) tick();
    check("drain_last", {29'd0, bus.state_o}, 32'd4);
    tick(); check("drain_done", {29'd0, bus.state_o}, 32'd1);

    // Single step stalled by the hazard unit for three cycles.
    bus.step_i = 1'b1;
    tick(); bus.step_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("step_held", {29'd0, bus.state_o}, 32'd3);
      tick();
    end
    check("step_held_4", {29'd0, bus.state_o}, 32'd3);
    bus.fetch_ok_i = 1'b1;
    tick(); bus.fetch_ok_i = 1'b0;
    check("step_to_drain", {29'd0, bus.state_o}, 32'd4);
    check("step_fetch", {16'd0, bus.fetch_cnt_o}, 32'd12);
    for (int i = 0; i < DRAIN; i++) tick();
    check("step_halted", {29'd0, bus.state_o}, 32'd1);

    // Breakpoint at 0x0C with the PC advancing by four per fetch.
    bus.bp_en_i = 1'b1; bus.bp_addr_i = 8'h0C; bus.pc_f_i = 8'h00; bus.fetch_ok_i = 1'b1;
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    tick(); bus.pc_f_i = 8'h04;
    tick(); bus.pc_f_i = 8'h08;
    tick(); bus.pc_f_i = 8'h0C;
    #1 check("bp_gates_en", {31'd0, bus.run_en_o}, 32'd0);
    tick();
    check("bp_drain", {29'd0, bus.state_o}, 32'd4);
    check("bp_hit_set", {31'd0, bus.bp_hit_o}, 32'd1);
    for (int i = 0; i < DRAIN; i++) tick();
    check("bp_halted", {29'd0, bus.state_o}, 32'd1);
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    #1 check("bp_resume_en", {31'd0, bus.run_en_o}, 32'd1);
    tick(); bus.pc_f_i = 8'h10;
    check("bp_resume_run", {29'd0, bus.state_o}, 32'd2);
    check("bp_hit_cleared", {31'd0, bus.bp_hit_o}, 32'd0);
`else
    bus.pc_f_i = 8'h0C;
    #1 check("bp_ignored_en", {31'd0, bus.run_en_o}, 32'd1);
    tick();
    check("bp_ignored_run", {29'd0, bus.state_o}, 32'd2);
    check("bp_ignored_hit", {31'd0, bus.bp_hit_o}, 32'd0);
`endif
    bus.halt_i = 1'b1;
    tick(); bus.halt_i = 1'b0;
    for (int i = 0; i < DRAIN; i++) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.start_i    = ($urandom % 8) == 0;
      bus.halt_i     = ($urandom % 12) == 0;
      bus.step_i     = ($urandom % 8) == 0;
      bus.fetch_ok_i = ($urandom % 4) != 0;
      bus.pc_f_i     = 8'($urandom_range(0, 5) * 4);
      bus.bp_en_i    = ($urandom % 4) != 0;
      bus.bp_addr_i  = 8'($urandom_range(1, 4) * 4);
      bus.clr_cnt_i  = ($urandom % 40) == 0;
      tick();
    end

    // Settle into HALTED, then a clear during an active fetch.
    idle_inputs();
    bus.halt_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.halt_i = 1'b0;
    check("settled", {29'd0, bus.state_o}, 32'd1);
    bus.start_i = 1'b1; bus.fetch_ok_i = 1'b1;
    tick(); bus.start_i = 1'b0;
    tick(); bus.clr_cnt_i = 1'b1;
    tick(); bus.clr_cnt_i = 1'b0;
    check("clr_wins_fetch", {16'd0, bus.fetch_cnt_o}, 32'd0);
    check("clr_wins_cycle", {16'd0, bus.cycle_cnt_o}, 32'd0);
    bus.halt_i = 1'b1;
    tick(); bus.halt_i = 1'b0; bus.fetch_ok_i = 1'b0;
    for (int i = 0; i < DRAIN; i++) tick();

    // Cycle counter wrap.
    bus.clr_cnt_i = 1'b1;
    tick(); bus.clr_cnt_i = 1'b0;
    for (int i = 0; i < 65535; i++) tick();
    check("cyc_max", {16'd0, bus.cycle_cnt_o}, 32'h0000_FFFF);
    tick(); check("cyc_wrap", {16'd0, bus.cycle_cnt_o}, 32'd0);

    // Asynchronous reset in the middle of a drain.
    bus.start_i = 1'b1;
    tick(); bus.start_i = 1'b0; bus.halt_i = 1'b1;
    tick(); bus.halt_i = 1'b0;
    check("pre_rst_drain", {29'd0, bus.state_o}, 32'd4);
    tick();
    rst = 1'b0;
    #1;
    check("async_rst_state", {29'd0, bus.state_o}, 32'd0);
    check("async_rst_run_en", {31'd0, bus.run_en_o}, 32'd0);
    check("async_rst_halted", {31'd0, bus.halted_o}, 32'd0);
    check("async_rst_bp_hit", {31'd0, bus.bp_hit_o}, 32'd0);
    check("async_rst_cyc", {16'd0, bus.cycle_cnt_o}, 32'd0);
    check("async_rst_fetch", {16'd0, bus.fetch_cnt_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(); check("rehold", {29'd0, bus.state_o}, 32'd0);
    tick(); check("rehold_exit", {29'd0, bus.state_o}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
